stage_ex: RTL

- Execute stage of the 5-stage MIPS pipeline.
- Consumes the ex_* outputs of the ID/EX pipeline register and drives the EX/MEM pipeline register.
- Combinational ALU, shifter and link path, plus architectural HI/LO registers and a sequential 32-cycle radix-2 divider.
- While a division is in flight, raises stall_request to the stall controller.

---
 rtl/stage_ex_pkg.sv | 57 +++++
 rtl/ex_divider.sv | 76 +++++++
 rtl/stage_ex.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/stage_ex_pkg.sv
// Shared opcode/category codes, enables and divider state encodings for the execute stage.
// The divider itself is only built when EX_DIV_EN is defined.
package stage_ex_pkg;

   localparam logic RESET_ENABLE  = 1'b1;
   localparam logic WRITE_ENABLE  = 1'b1;
   localparam logic WRITE_DISABLE = 1'b0;
   localparam logic STALL_ENABLE  = 1'b1;
   localparam logic STALL_DISABLE = 1'b0;

   localparam logic [2:0] CATEGORY_NONE       = 3'd0;
   localparam logic [2:0] CATEGORY_LOGIC      = 3'd1;
   localparam logic [2:0] CATEGORY_SHIFT      = 3'd2;
   localparam logic [2:0] CATEGORY_ARITH      = 3'd3;
   localparam logic [2:0] CATEGORY_MOVE       = 3'd4;
   localparam logic [2:0] CATEGORY_JUMP       = 3'd5;
   localparam logic [2:0] CATEGORY_LOAD_STORE = 3'd6;

   localparam logic [7:0] OP_NOP   = 8'd0;
   localparam logic [7:0] OP_AND   = 8'd1;
   localparam logic [7:0] OP_OR    = 8'd2;
   localparam logic [7:0] OP_XOR   = 8'd3;
   localparam logic [7:0] OP_NOR   = 8'd4;
   localparam logic [7:0] OP_SLL   = 8'd5;
   localparam logic [7:0] OP_SRL   = 8'd6;
   localparam logic [7:0] OP_SRA   = 8'd7;
   localparam logic [7:0] OP_ADD   = 8'd8;
   localparam logic [7:0] OP_ADDU  = 8'd9;
   localparam logic [7:0] OP_SUB   = 8'd10;
   localparam logic [7:0] OP_SUBU  = 8'd11;
   localparam logic [7:0] OP_SLT   = 8'd12;
   localparam logic [7:0] OP_SLTU  = 8'd13;
   localparam logic [7:0] OP_MUL   = 8'd14;
   localparam logic [7:0] OP_MULT  = 8'd15;
   localparam logic [7:0] OP_MULTU = 8'd16;
   localparam logic [7:0] OP_DIV   = 8'd17;
   localparam logic [7:0] OP_DIVU  = 8'd18;
   localparam logic [7:0] OP_MFHI  = 8'd19;
   localparam logic [7:0] OP_MFLO  = 8'd20;
   localparam logic [7:0] OP_MTHI  = 8'd21;
   localparam logic [7:0] OP_MTLO  = 8'd22;
   localparam logic [7:0] OP_JAL   = 8'd23;
   localparam logic [7:0] OP_LW    = 8'd24;
   localparam logic [7:0] OP_SW    = 8'd25;

   typedef enum logic [1:0] {DivIdle, DivBusy, DivDone} div_state_e;

   // One restoring shift-subtract step on {remainder, quotient}; returns the updated pair.
   function automatic logic [63:0] div_step(input logic [31:0] rem, input logic [31:0] quo,
                                            input logic [31:0] dsr);
      logic [32:0] trial;
      trial = {rem, quo[31]} - {1'b0, dsr};
      if (trial[32]) return {rem[30:0], quo[31], quo[30:0], 1'b0};
      return {trial[31:0], quo[30:0], 1'b1};
   endfunction

endpackage

// File: rtl/ex_divider.sv
// Sequential 32-step restoring divider with signed fix-up, used when EX_DIV_EN is defined.
// The first step is folded into the load so the busy phase lasts DIV_CYCLES-1 cycles.
module ex_divider
   import stage_ex_pkg::*;
#(
   parameter int unsigned DIV_CYCLES = 32
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        start,
   input  logic        signed_op,
   input  logic [31:0] dividend,
   input  logic [31:0] divisor,
   input  logic        ack,
   output logic        busy,
   output logic        done,
   output logic [31:0] quotient,
   output logic [31:0] remainder
);

   div_state_e  state_q;
   logic [31:0] rem_q, quo_q, dsr_q;
   logic [5:0]  count_q;
   logic        neg_quo_q, neg_rem_q;

   logic        dividend_neg, divisor_neg;
   logic [31:0] dividend_mag, divisor_mag;
   logic [63:0] first_step, next_step;

   assign dividend_neg = signed_op & dividend[31];
   assign divisor_neg  = signed_op & divisor[31];
   assign dividend_mag = dividend_neg ? -dividend : dividend;
   assign divisor_mag  = divisor_neg ? -divisor : divisor;
   assign first_step   = div_step(32'd0, dividend_mag, divisor_mag);
   assign next_step    = div_step(rem_q, quo_q, dsr_q);

   always_ff @(posedge clock) begin
      if (reset == RESET_ENABLE) begin
         state_q   <= DivIdle;
         rem_q     <= '0;
         quo_q     <= '0;
         dsr_q     <= '0;
         count_q   <= '0;
         neg_quo_q <= 1'b0;
         neg_rem_q <= 1'b0;
      end else begin
         case (state_q)
            DivIdle: begin
               if (start) begin
                  state_q            <= DivBusy;
                  {rem_q, quo_q}     <= first_step;
                  dsr_q              <= divisor_mag;
                  count_q            <= '0;
                  neg_quo_q          <= dividend_neg ^ divisor_neg;
                  neg_rem_q          <= dividend_neg;
               end
            end
            DivBusy: begin
               {rem_q, quo_q} <= next_step;
               count_q        <= count_q + 6'd1;
               if (count_q == 6'(DIV_CYCLES - 2)) state_q <= DivDone;
            end
            DivDone: begin
               if (ack) state_q <= DivIdle;
            end
            default: state_q <= DivIdle;
         endcase
      end
   end

   assign busy      = (state_q == DivBusy);
   assign done      = (state_q == DivDone);
   assign quotient  = neg_quo_q ? -quo_q : quo_q;
   assign remainder = neg_rem_q ? -rem_q : rem_q;

endmodule

// File: rtl/stage_ex.sv
// MIPS execute stage: combinational ALU/shift/link/address paths plus HI/LO state.
// Define EX_DIV_EN to include the multi-cycle divider; otherwise DIV/DIVU behave as NOPs.
module stage_ex
   import stage_ex_pkg::*;
#(
   parameter int unsigned DIV_CYCLES = 32
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        stall_hold,
   input  logic [31:0] ex_instruction,
   input  logic [7:0]  ex_operator,
   input  logic [2:0]  ex_category,
   input  logic [31:0] ex_operand_a,
   input  logic [31:0] ex_operand_b,
   input  logic        ex_reg_write_enable,
   input  logic [4:0]  ex_reg_write_address,
   input  logic [31:0] ex_reg_write_data,
   output logic [7:0]  mem_operator,
   output logic        mem_reg_write_enable,
   output logic [4:0]  mem_reg_write_address,
   output logic [31:0] mem_reg_write_data,
   output logic [31:0] mem_address,
   output logic [31:0] mem_store_data,
   output logic        stall_request
);

   logic [31:0] a, b, sum, diff, hi_q, lo_q, hi_d, lo_d, result;
   logic [63:0] prod_s, prod_u;
   logic        add_ovf, sub_ovf, is_div, write_en;
   logic        div_busy, div_done, div_zero;
   logic [31:0] div_quo, div_rem;
   logic        unused_instr;

   assign a       = ex_operand_a;
   assign b       = ex_operand_b;
   assign sum     = a + b;
   assign diff    = a - b;
   assign add_ovf = (a[31] == b[31]) && (sum[31] != a[31]);
   assign sub_ovf = (a[31] != b[31]) && (diff[31] != a[31]);
   assign prod_s  = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
   assign prod_u  = {32'd0, a} * {32'd0, b};
   assign is_div  = (ex_operator == OP_DIV) || (ex_operator == OP_DIVU);
   assign unused_instr = ^ex_instruction[31:16];

`ifdef EX_DIV_EN
   localparam logic DivEnable = 1'b1;
   logic div_start;

   // Division starts only from idle; a held DONE must not re-trigger it.
   assign div_start = is_div && (b != '0) && !div_busy && !div_done;
   assign div_zero  = is_div && (b == '0) && !div_busy && !div_done;

   ex_divider #(
      .DIV_CYCLES(DIV_CYCLES)
   ) u_divider (
      .clock    (clock),
      .reset    (reset),
      .start    (div_start),
      .signed_op(ex_operator == OP_DIV),
      .dividend (a),
      .divisor  (b),
      .ack      (!stall_hold),
      .busy     (div_busy),
      .done     (div_done),
      .quotient (div_quo),
      .remainder(div_rem)
   );

   assign stall_request = (div_start || div_busy) ? STALL_ENABLE : STALL_DISABLE;
`else
   localparam logic DivEnable = 1'b0;
   localparam int unsigned unused_div_cycles = DIV_CYCLES;

   assign div_busy      = 1'b0;
   assign div_done      = 1'b0;
   assign div_zero      = 1'b0;
   assign div_quo       = '0;
   assign div_rem       = '0;
   assign stall_request = STALL_DISABLE;
`endif

   always_comb begin
      result   = '0;
      write_en = ex_reg_write_enable;
      case (ex_category)
         CATEGORY_LOGIC: begin
            case (ex_operator)
               OP_AND:  result = a & b;
               OP_OR:   result = a | b;
               OP_XOR:  result = a ^ b;
               OP_NOR:  result = ~(a | b);
               default: result = '0;
            endcase
         end
         CATEGORY_SHIFT: begin
            case (ex_operator)
               OP_SLL:  result = b << a[4:0];
               OP_SRL:  result = b >> a[4:0];
               OP_SRA:  result = $signed(b) >>> a[4:0];
               default: result = '0;
            endcase
         end
         CATEGORY_ARITH: begin
            case (ex_operator)
               OP_ADD, OP_ADDU: result = sum;
               OP_SUB, OP_SUBU: result = diff;
               OP_SLT:          result = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
               OP_SLTU:         result = (a < b) ? 32'd1 : 32'd0;
               OP_MUL:          result = prod_s[31:0];
               default:         result = '0;
            endcase
            if ((ex_operator == OP_ADD && add_ovf) || (ex_operator == OP_SUB && sub_ovf)) begin
               write_en = WRITE_DISABLE;
            end
         end
         CATEGORY_MOVE: begin
            case (ex_operator)
               OP_MFHI: result = hi_q;
               OP_MFLO: result = lo_q;
               default: result = '0;
            endcase
         end
         CATEGORY_JUMP:       result = ex_reg_write_data;
         CATEGORY_LOAD_STORE: result = '0;
         default:             write_en = WRITE_DISABLE;
      endcase
      if (is_div && !DivEnable) write_en = WRITE_DISABLE;
   end

   // Writers are ignored while a division is in flight; a finished division always wins.
   always_comb begin
      hi_d = hi_q;
      lo_d = lo_q;
      if (!stall_hold) begin
         if (!div_busy) begin
            case (ex_operator)
               OP_MTHI:  hi_d = a;
               OP_MTLO:  lo_d = a;
               OP_MULT:  {hi_d, lo_d} = prod_s;
               OP_MULTU: {hi_d, lo_d} = prod_u;
               default:  ;
            endcase
         end
         if (div_zero) begin
            hi_d = a;
            lo_d = '1;
         end
         if (div_done) begin
            hi_d = div_rem;
            lo_d = div_quo;
         end
      end
   end

   always_ff @(posedge clock) begin
      if (reset == RESET_ENABLE) begin
         hi_q <= '0;
         lo_q <= '0;
      end else begin
         hi_q <= hi_d;
         lo_q <= lo_d;
      end
   end

   assign mem_operator          = ex_operator;
   assign mem_reg_write_enable  = write_en;
   assign mem_reg_write_address = ex_reg_write_address;
   assign mem_reg_write_data    = result;
   assign mem_address           = a + {{16{ex_instruction[15]}}, ex_instruction[15:0]};
   assign mem_store_data        = b;

endmodule
